id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register of the 16-bit MIPS core.
- Drives the register-file read addresses from the IF/ID instruction and captures the returned operands.
- Resolves write-back and MEM-stage forwarding, detects load-use hazards (stall and bubble), and presents registered operands and control to EX.

---
 rtl/id_ex_stage_pkg.sv | 38 +++
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/id_ex_stage_id_decoder.sv | 43 ++++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode definitions for the ID/EX stage: opcodes, instruction field positions
// and the decoded-control bundle produced by id_decoder.
package id_ex_stage_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int FN_MSB  = 2;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    DEST_RT = 1'b0,
    DEST_RD = 1'b1
  } dest_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      uses_rs;
    logic      uses_rt;
    dest_sel_e dest_sel;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between IF/ID, register file, MEM/WB bypass sources and EX for id_ex_stage.
// The stage itself binds to the slave modport; stall_cnt exists only with ID_STALL_CNT_EN.
interface id_ex_stage_if #(
  parameter int inst_SIZE = 16,
  parameter int REG_AW    = 3
);
  logic                 if_valid;
  logic [inst_SIZE-1:0] if_inst;
  logic                 if_ready;
  logic [REG_AW-1:0]    rf_rs;
  logic [REG_AW-1:0]    rf_rt;
  logic [inst_SIZE-1:0] rf_rdata1;
  logic [inst_SIZE-1:0] rf_rdata2;
  logic                 mem_wr;
  logic [REG_AW-1:0]    mem_rd;
  logic                 mem_load;
  logic [inst_SIZE-1:0] mem_result;
  logic                 wb_wr;
  logic [REG_AW-1:0]    wb_rd;
  logic [inst_SIZE-1:0] wb_data;
  logic                 ex_stall;
  logic                 flush;
  logic                 ex_valid;
  logic [3:0]           ex_opcode;
  logic [2:0]           ex_funct;
  logic [REG_AW-1:0]    ex_rd;
  logic [inst_SIZE-1:0] ex_op_a;
  logic [inst_SIZE-1:0] ex_op_b;
  logic [inst_SIZE-1:0] ex_imm;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_branch;
  logic                 ex_fwd_a;
  logic                 ex_fwd_b;
`ifdef ID_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  modport slave (
    input  if_valid, if_inst, rf_rdata1, rf_rdata2,
    input  mem_wr, mem_rd, mem_load, mem_result,
    input  wb_wr, wb_rd, wb_data, ex_stall, flush,
    output if_ready, rf_rs, rf_rt,
    output ex_valid, ex_opcode, ex_funct, ex_rd, ex_op_a, ex_op_b, ex_imm,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_fwd_a, ex_fwd_b
`ifdef ID_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport master (
    output if_valid, if_inst, rf_rdata1, rf_rdata2,
    output mem_wr, mem_rd, mem_load, mem_result,
    output wb_wr, wb_rd, wb_data, ex_stall, flush,
    input  if_ready, rf_rs, rf_rt,
    input  ex_valid, ex_opcode, ex_funct, ex_rd, ex_op_a, ex_op_b, ex_imm,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_fwd_a, ex_fwd_b
`ifdef ID_STALL_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/id_ex_stage_id_decoder.sv
// Opcode to control-bundle decoder, shared by the hazard and pipeline-register logic.
// Latency: purely combinational. Backpressure: none, no state.
module id_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.dest_sel = DEST_RT;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.dest_sel  = DEST_RD;
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.uses_rs   = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode + ID/EX register with MEM/WB bypass, load-use bubbles; optional ID_STALL_CNT_EN stall counter.
// Latency: 1 cycle from if_inst acceptance to ex_* outputs.
// Backpressure: if_ready drops on ex_stall (register held) or a load-use hazard (bubble issued).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int inst_SIZE = 16,
  parameter int REG_AW    = 3
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ctrl_t                ctrl;
  logic [REG_AW-1:0]    rs, rt, dest;
  logic                 ld_dep_rs, ld_dep_rt, hz, issue;
  logic                 prod_rs, prod_rt;
  logic [inst_SIZE-1:0] op_a_sel, op_b_sel, imm_sext;

  id_decoder u_decoder (
    .opcode (bus.if_inst[OPC_MSB:OPC_LSB]),
    .ctrl   (ctrl)
  );

  assign rs        = bus.if_inst[RS_MSB:RS_LSB];
  assign rt        = bus.if_inst[RT_MSB:RT_LSB];
  assign dest      = (ctrl.dest_sel == DEST_RD) ? bus.if_inst[RD_MSB:RD_LSB] : rt;
  assign imm_sext  = {{(inst_SIZE-6){bus.if_inst[IMM_MSB]}}, bus.if_inst[IMM_MSB:IMM_LSB]};
  assign bus.rf_rs = rs;
  assign bus.rf_rt = rt;

  // A loaded value is unusable both while the LW sits in EX and while it sits in MEM.
  always_comb begin
    ld_dep_rs = (bus.ex_valid && bus.ex_mem_read && bus.ex_rd == rs) ||
                (bus.mem_wr && bus.mem_load && bus.mem_rd == rs);
    ld_dep_rt = (bus.ex_valid && bus.ex_mem_read && bus.ex_rd == rt) ||
                (bus.mem_wr && bus.mem_load && bus.mem_rd == rt);
    hz        = bus.if_valid && ((ctrl.uses_rs && ld_dep_rs) || (ctrl.uses_rt && ld_dep_rt));
    prod_rs   = bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read && bus.ex_rd == rs;
    prod_rt   = bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read && bus.ex_rd == rt;
    issue     = bus.if_valid && !bus.flush && !hz;
  end

  // MEM result beats WB data; WB also covers a same-edge register-file write.
  always_comb begin
    if (bus.mem_wr && !bus.mem_load && bus.mem_rd == rs)
      op_a_sel = bus.mem_result;
    else if (bus.wb_wr && bus.wb_rd == rs)
      op_a_sel = bus.wb_data;
    else
      op_a_sel = bus.rf_rdata1;

    if (bus.mem_wr && !bus.mem_load && bus.mem_rd == rt)
      op_b_sel = bus.mem_result;
    else if (bus.wb_wr && bus.wb_rd == rt)
      op_b_sel = bus.wb_data;
    else
      op_b_sel = bus.rf_rdata2;
  end

  assign bus.if_ready = !bus.ex_stall && (bus.flush || !hz);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_opcode    <= '0;
      bus.ex_funct     <= '0;
      bus.ex_rd        <= '0;
      bus.ex_op_a      <= '0;
      bus.ex_op_b      <= '0;
      bus.ex_imm       <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_branch    <= 1'b0;
      bus.ex_fwd_a     <= 1'b0;
      bus.ex_fwd_b     <= 1'b0;
    end else if (!bus.ex_stall) begin
      bus.ex_valid     <= issue;
      bus.ex_reg_write <= issue && ctrl.reg_write;
      bus.ex_mem_read  <= issue && ctrl.mem_read;
      bus.ex_mem_write <= issue && ctrl.mem_write;
      bus.ex_branch    <= issue && ctrl.branch;
      bus.ex_fwd_a     <= issue && ctrl.uses_rs && prod_rs;
      bus.ex_fwd_b     <= issue && ctrl.uses_rt && prod_rt;
      if (issue) begin
        bus.ex_opcode <= bus.if_inst[OPC_MSB:OPC_LSB];
        bus.ex_funct  <= bus.if_inst[FN_MSB:FN_LSB];
        bus.ex_rd     <= dest;
        bus.ex_op_a   <= op_a_sel;
        bus.ex_op_b   <= op_b_sel;
        bus.ex_imm    <= imm_sext;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (bus.if_valid && !bus.if_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios followed by random traffic.
// A spec-level model predicts each cycle's ID/EX contents; a negedge monitor pops and compares.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.inst_SIZE(16), .REG_AW(3)) bus ();

  id_ex_stage #(.inst_SIZE(16), .REG_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        iv;
    bit [15:0] inst;
    bit [15:0] d1, d2;
    bit        mw;
    bit [2:0]  mrd;
    bit        ml;
    bit [15:0] mres;
    bit        ww;
    bit [2:0]  wrd;
    bit [15:0] wd;
    bit        st, fl;
  } in_t;

  typedef struct {
    bit        valid;
    bit [3:0]  opc;
    bit [2:0]  funct, rd;
    bit [15:0] a, b, imm;
    bit        rw, mr, mw, br, fa, fb, ua, ub;
  } exp_t;

  exp_t        q[$];
  exp_t        mst, pend, mon_e;
  bit          have_pend;
  int          n_chk, n_fail;
  int unsigned mcnt;
  in_t         x;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] ins(input bit [3:0] opc, input bit [2:0] rs, input bit [2:0] rt,
                                    input bit [2:0] rd, input bit [2:0] fn);
    return {opc, rs, rt, rd, fn};
  endfunction

  function automatic in_t idle();
    in_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic bit load_busy(input exp_t c, input in_t i, input bit [2:0] r);
    return (c.valid && c.mr && c.rd == r) || (i.mw && i.ml && i.mrd == r);
  endfunction

  function automatic bit producer(input exp_t c, input bit [2:0] r);
    return c.valid && c.rw && !c.mr && c.rd == r;
  endfunction

  function automatic bit [15:0] operand(input in_t i, input bit [2:0] r, input bit [15:0] rf);
    if (i.mw && !i.ml && i.mrd == r) return i.mres;
    if (i.ww && i.wrd == r) return i.wd;
    return rf;
  endfunction

  // Reference: what EX should hold after the next edge, given its current contents and this cycle's inputs.
  function automatic exp_t model_next(input exp_t cur, input in_t i, output bit rdy);
    exp_t     n;
    bit [3:0] opc;
    bit [2:0] rs, rt;
    bit       ua, ub, hz;
    opc = i.inst[15:12];
    rs  = i.inst[11:9];
    rt  = i.inst[8:6];
    ua  = (opc <= 4'hA);
    ub  = (opc == 4'h0) || (opc == 4'h9) || (opc == 4'hA);
    hz  = i.iv && ((ua && load_busy(cur, i, rs)) || (ub && load_busy(cur, i, rt)));
    rdy = !i.st && (i.fl || !hz);
    n   = '{default: 0};
    if (i.st) return cur;
    if (i.fl || hz || !i.iv) return n;
    n.valid = 1;
    n.opc   = opc;
    n.funct = i.inst[2:0];
    n.rd    = (opc == 4'h0) ? i.inst[5:3] : rt;
    n.imm   = {{10{i.inst[5]}}, i.inst[5:0]};
    n.rw    = (opc <= 4'h8);
    n.mr    = (opc == 4'h8);
    n.mw    = (opc == 4'h9);
    n.br    = (opc == 4'hA);
    n.ua    = ua;
    n.ub    = ub;
    n.a     = operand(i, rs, i.d1);
    n.b     = operand(i, rt, i.d2);
    n.fa    = ua && producer(cur, rs);
    n.fb    = ub && producer(cur, rt);
    return n;
  endfunction

  task automatic apply(input in_t i);
    bus.if_valid   = i.iv;
    bus.if_inst    = i.inst;
    bus.rf_rdata1  = i.d1;
    bus.rf_rdata2  = i.d2;
    bus.mem_wr     = i.mw;
    bus.mem_rd     = i.mrd;
    bus.mem_load   = i.ml;
    bus.mem_result = i.mres;
    bus.wb_wr      = i.ww;
    bus.wb_rd      = i.wrd;
    bus.wb_data    = i.wd;
    bus.ex_stall   = i.st;
    bus.flush      = i.fl;
  endtask

  // One cycle: publish last prediction, drive inputs, check combinational outputs, predict next edge.
  task automatic step(input in_t i);
    bit rdy;
    @(posedge clk);
    #1;
    if (have_pend) begin
      q.push_back(pend);
      have_pend = 0;
    end
    apply(i);
    #2;
    pend = model_next(mst, i, rdy);
    chk("if_ready", bus.if_ready, rdy);
    chk("rf_rs", bus.rf_rs, i.inst[11:9]);
    chk("rf_rt", bus.rf_rt, i.inst[8:6]);
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, mcnt);
    if (i.iv && !rdy && mcnt != 32'hFFFF) mcnt++;
`endif
    mst       = pend;
    have_pend = 1;
  endtask

  always @(negedge clk) begin
    if (rst && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("ex_valid", bus.ex_valid, mon_e.valid);
      chk("ex_reg_write", bus.ex_reg_write, mon_e.rw);
      chk("ex_mem_read", bus.ex_mem_read, mon_e.mr);
      chk("ex_mem_write", bus.ex_mem_write, mon_e.mw);
      chk("ex_branch", bus.ex_branch, mon_e.br);
      if (mon_e.valid) begin
        chk("ex_opcode", bus.ex_opcode, mon_e.opc);
        chk("ex_funct", bus.ex_funct, mon_e.funct);
        chk("ex_imm", bus.ex_imm, mon_e.imm);
        chk("ex_fwd_a", bus.ex_fwd_a, mon_e.fa);
        chk("ex_fwd_b", bus.ex_fwd_b, mon_e.fb);
        if (mon_e.rw) chk("ex_rd", bus.ex_rd, mon_e.rd);
        if (mon_e.ua && !mon_e.fa) chk("ex_op_a", bus.ex_op_a, mon_e.a);
        if (mon_e.ub && !mon_e.fb) chk("ex_op_b", bus.ex_op_b, mon_e.b);
      end
    end
  end

  initial begin
    int unsigned c0;
    n_chk = 0;
    n_fail = 0;
    mcnt = 0;
    have_pend = 0;
    mst = '{default: 0};
    c0 = 0;
    apply(idle());
    #2;
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_reg_write", bus.ex_reg_write, 1'b0);
    chk("rst_ex_op_a", bus.ex_op_a, 16'h0);
    chk("rst_ex_fwd_a", bus.ex_fwd_a, 1'b0);
    chk("rst_if_ready", bus.if_ready, 1'b1);
    #10 rst = 1'b1;

    // ADD r3,r1,r2
    x = idle(); x.iv = 1; x.inst = ins(4'h0, 3'd1, 3'd2, 3'd3, 3'd0); x.d1 = 16'h0005; x.d2 = 16'h0007;
    step(x);
    step(idle());
    chk("add_valid", bus.ex_valid, 1'b1);
    chk("add_op_a", bus.ex_op_a, 16'h0005);
    chk("add_op_b", bus.ex_op_b, 16'h0007);
    chk("add_rd", bus.ex_rd, 3'd3);
    chk("add_reg_write", bus.ex_reg_write, 1'b1);

    // I-type with negative immediate: dest is rt
    x = idle(); x.iv = 1; x.inst = ins(4'h1, 3'd4, 3'd5, 3'b111, 3'b110);
    step(x);
    step(idle());
    chk("itype_imm", bus.ex_imm, 16'hFFFE);
    chk("itype_rd", bus.ex_rd, 3'd5);

    // WB bypass, then MEM bypass taking priority over WB
    x = idle(); x.iv = 1; x.inst = ins(4'h0, 3'd1, 3'd2, 3'd3, 3'd0);
    x.ww = 1; x.wrd = 3'd1; x.wd = 16'hBEEF;
    step(x);
    step(idle());
    chk("wb_fwd_op_a", bus.ex_op_a, 16'hBEEF);
    x.mw = 1; x.mrd = 3'd1; x.mres = 16'h1234;
    step(x);
    step(idle());
    chk("mem_fwd_op_a", bus.ex_op_a, 16'h1234);

    // LW r2 then ADD r4,r2,r2: two stall cycles, then WB supplies the loaded value
    x = idle(); x.iv = 1; x.inst = ins(4'h8, 3'd1, 3'd2, 3'd0, 3'd0);
    step(x);
`ifdef ID_STALL_CNT_EN
    c0 = bus.stall_cnt;
`endif
    x = idle(); x.iv = 1; x.inst = ins(4'h0, 3'd2, 3'd2, 3'd4, 3'd0);
    step(x);
    chk("lu_stall1", bus.if_ready, 1'b0);
    x.mw = 1; x.mrd = 3'd2; x.ml = 1;
    step(x);
    chk("lu_stall2", bus.if_ready, 1'b0);
    chk("lu_bubble1", bus.ex_valid, 1'b0);
    x.mw = 0; x.ml = 0; x.ww = 1; x.wrd = 3'd2; x.wd = 16'hCAFE;
    step(x);
    chk("lu_accept", bus.if_ready, 1'b1);
    chk("lu_bubble2", bus.ex_valid, 1'b0);
`ifdef ID_STALL_CNT_EN
    chk("lu_stall_cnt", bus.stall_cnt - c0, 2);
`endif
    step(idle());
    chk("lu_valid", bus.ex_valid, 1'b1);
    chk("lu_op_a", bus.ex_op_a, 16'hCAFE);
    chk("lu_op_b", bus.ex_op_b, 16'hCAFE);

    // ADD r5 then SUB r6,r5,r1: EX-result forwarding, no stall
    x = idle(); x.iv = 1; x.inst = ins(4'h0, 3'd1, 3'd2, 3'd5, 3'd0);
    step(x);
    x.inst = ins(4'h0, 3'd5, 3'd1, 3'd6, 3'd1);
    step(x);
    chk("exfwd_no_stall", bus.if_ready, 1'b1);
    step(idle());
    chk("exfwd_fwd_a", bus.ex_fwd_a, 1'b1);
    chk("exfwd_fwd_b", bus.ex_fwd_b, 1'b0);

    // flush during load-use hazard
    x = idle(); x.iv = 1; x.inst = ins(4'h8, 3'd1, 3'd2, 3'd0, 3'd0);
    step(x);
    x.inst = ins(4'h0, 3'd2, 3'd2, 3'd4, 3'd0); x.fl = 1;
    step(x);
    chk("flush_hz_ready", bus.if_ready, 1'b1);
    step(idle());
    chk("flush_hz_bubble", bus.ex_valid, 1'b0);

    // flush while EX is stalled is ignored
    x = idle(); x.iv = 1; x.inst = ins(4'h0, 3'd1, 3'd2, 3'd3, 3'd0);
    step(x);
    x.inst = ins(4'h0, 3'd1, 3'd2, 3'd7, 3'd0); x.st = 1; x.fl = 1;
    step(x);
    chk("stall_flush_ready", bus.if_ready, 1'b0);
    step(idle());
    chk("stall_hold_valid", bus.ex_valid, 1'b1);
    chk("stall_hold_rd", bus.ex_rd, 3'd3);

    // asynchronous reset in the middle of a stall
    x = idle(); x.iv = 1; x.inst = ins(4'h8, 3'd1, 3'd2, 3'd0, 3'd0);
    step(x);
    x.inst = ins(4'h0, 3'd2, 3'd2, 3'd4, 3'd0); x.st = 1;
    step(x);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ex_valid", bus.ex_valid, 1'b0);
    chk("midrst_ex_mem_read", bus.ex_mem_read, 1'b0);
`ifdef ID_STALL_CNT_EN
    chk("midrst_stall_cnt", bus.stall_cnt, 0);
`endif
    q.delete();
    have_pend = 0;
    mst = '{default: 0};
    mcnt = 0;
    apply(idle());
    #4 rst = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      x      = idle();
      x.iv   = ($urandom_range(0, 3) != 0);
      x.inst = 16'($urandom);
      x.d1   = 16'($urandom);
      x.d2   = 16'($urandom);
      x.mw   = 1'($urandom);
      x.mrd  = 3'($urandom_range(0, 7));
      x.ml   = ($urandom_range(0, 2) == 0);
      x.mres = 16'($urandom);
      x.ww   = 1'($urandom);
      x.wrd  = 3'($urandom_range(0, 7));
      x.wd   = 16'($urandom);
      x.st   = ($urandom_range(0, 4) == 0);
      x.fl   = ($urandom_range(0, 7) == 0);
      step(x);
    end
    step(idle());
    step(idle());
    @(negedge clk);
    #1;
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
